// File: rtl/pipe_seq_ctrl.sv
// Central 5-stage pipeline sequencer: merges stall, branch, memory handshakes and halt/drain/resume.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_seq_ctrl #(
   parameter int DRAIN_CYC   = 3,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        hz_stall_i,
   input  logic        br_taken_i,
   input  logic        imem_ready_i,
   input  logic        dmem_ready_i,
   input  logic        mem_op_i,
   input  logic        halt_req_i,
   input  logic        resume_i,
   output logic        pc_we_o,
   output logic        pc_sel_o,
   output logic        if_id_we_o,
   output logic        id_ex_we_o,
   output logic        ex_mem_we_o,
   output logic        mem_wb_we_o,
   output logic        if_id_flush_o,
   output logic        id_ex_flush_o,
   output logic        ex_mem_flush_o,
   output logic [2:0]  state_o,
   output logic        err_o
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [31:0] cyc_cnt_o,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] flush_cnt_o
`endif
);

   typedef enum logic [2:0] {
      ST_RUN   = 3'd0,
      ST_DWAIT = 3'd1,
      ST_DRAIN = 3'd2,
      ST_HALT  = 3'd3,
      ST_ERR   = 3'd4
   } state_e;

   localparam logic [7:0] TMO_MAX   = 8'(MEM_TIMEOUT);
   localparam logic [7:0] DRAIN_INI = 8'(DRAIN_CYC - 1);

   state_e     state_q, state_d;
   logic [7:0] tmo_q, tmo_d;
   logic [7:0] drain_q, drain_d;
   logic       err_q, err_d;
   logic       run_dec, skip_mem;

   // Handshake: a data access in MEM is outstanding while mem_op_i=1 and completes
   // in the cycle dmem_ready_i=1; imem_ready_i=1 marks fetch data valid this cycle.
   always_comb begin
      state_d        = state_q;
      tmo_d          = tmo_q;
      drain_d        = drain_q;
      err_d          = err_q;
      pc_we_o        = 1'b0;
      pc_sel_o       = 1'b0;
      if_id_we_o     = 1'b0;
      id_ex_we_o     = 1'b0;
      ex_mem_we_o    = 1'b0;
      mem_wb_we_o    = 1'b0;
      if_id_flush_o  = 1'b0;
      id_ex_flush_o  = 1'b0;
      ex_mem_flush_o = 1'b0;
      run_dec        = 1'b0;
      skip_mem       = 1'b0;

      unique case (state_q)
         ST_RUN: run_dec = 1'b1;
         ST_DWAIT: begin
            if (dmem_ready_i) begin
               run_dec  = 1'b1;
               skip_mem = 1'b1;
            end else if (tmo_q >= TMO_MAX) begin
               state_d = ST_ERR;
               err_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         ST_DRAIN: begin
            // A pending data access freezes the drain without consuming a count.
            if (!(mem_op_i && !dmem_ready_i)) begin
               if_id_we_o    = 1'b1;
               if_id_flush_o = 1'b1;
               id_ex_we_o    = 1'b1;
               ex_mem_we_o   = 1'b1;
               mem_wb_we_o   = 1'b1;
               if (drain_q == 8'd0) state_d = ST_HALT;
               else                 drain_d = drain_q - 8'd1;
            end
         end
         ST_HALT: if (resume_i) state_d = ST_RUN;
         ST_ERR:  state_d = ST_ERR;
         default: state_d = ST_RUN;
      endcase

      if (run_dec) begin
         state_d = ST_RUN;
         if (!skip_mem && mem_op_i && !dmem_ready_i) begin
            state_d = ST_DWAIT;
            tmo_d   = 8'd1;
         end else if (br_taken_i) begin
            pc_we_o       = 1'b1;
            pc_sel_o      = 1'b1;
            if_id_we_o    = 1'b1;
            id_ex_we_o    = 1'b1;
            ex_mem_we_o   = 1'b1;
            mem_wb_we_o   = 1'b1;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
         end else if (hz_stall_i) begin
            id_ex_we_o    = 1'b1;
            id_ex_flush_o = 1'b1;
            ex_mem_we_o   = 1'b1;
            mem_wb_we_o   = 1'b1;
         end else if (halt_req_i || !imem_ready_i) begin
            if_id_we_o    = 1'b1;
            if_id_flush_o = 1'b1;
            id_ex_we_o    = 1'b1;
            ex_mem_we_o   = 1'b1;
            mem_wb_we_o   = 1'b1;
            if (halt_req_i) begin
               state_d = ST_DRAIN;
               drain_d = DRAIN_INI;
            end
         end else begin
            pc_we_o     = 1'b1;
            if_id_we_o  = 1'b1;
            id_ex_we_o  = 1'b1;
            ex_mem_we_o = 1'b1;
            mem_wb_we_o = 1'b1;
         end
      end

      if (rst_i) begin
         pc_we_o        = 1'b0;
         pc_sel_o       = 1'b0;
         if_id_we_o     = 1'b0;
         id_ex_we_o     = 1'b0;
         ex_mem_we_o    = 1'b0;
         mem_wb_we_o    = 1'b0;
         if_id_flush_o  = 1'b1;
         id_ex_flush_o  = 1'b1;
         ex_mem_flush_o = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_RUN;
         tmo_q   <= 8'd0;
         drain_q <= 8'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         drain_q <= drain_d;
         err_q   <= err_d;
      end
   end

   assign state_o = state_q;
   assign err_o   = err_q & ~rst_i;

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] cyc_q, stall_q, flush_q;
   logic        frozen, in_run;

   assign frozen = (state_q == ST_HALT) || (state_q == ST_ERR);
   assign in_run = (state_q == ST_RUN) || (state_q == ST_DWAIT);

   // pc_sel_o is high exactly when a taken branch is accepted.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cyc_q   <= 32'd0;
         stall_q <= 32'd0;
         flush_q <= 32'd0;
      end else if (!frozen) begin
         cyc_q <= cyc_q + 32'd1;
         if (in_run && !pc_we_o) stall_q <= stall_q + 32'd1;
         if (pc_sel_o)           flush_q <= flush_q + 32'd1;
      end
   end

   assign cyc_cnt_o   = cyc_q;
   assign stall_cnt_o = stall_q;
   assign flush_cnt_o = flush_q;
`endif

endmodule
